measure_requester: RTL and testbench

//  Host-side initiator for the oscillator-measurement link. On a start pulse it sends one

---
 rtl/meas_link_pkg.sv | 24 ++
 rtl/reload_timer.sv | 31 +++
 rtl/measure_requester.sv | 113 +++++++++++
 tb/tb_measure_requester.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/meas_link_pkg.sv
// Shared definitions for the oscillator-measurement link: command code, reply size, FSM encoding.
package meas_link_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned REPLY_BYTES = 3;
  localparam logic [BYTE_W-1:0] CMD_MEASURE = 8'h01;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SEND = 3'd1;
  localparam logic [2:0] ST_RX0  = 3'd2;
  localparam logic [2:0] ST_RX1  = 3'd3;
  localparam logic [2:0] ST_RX2  = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    SEND = ST_SEND,
    RX0  = ST_RX0,
    RX1  = ST_RX1,
    RX2  = ST_RX2,
    DONE = ST_DONE
  } meas_state_e;

endpackage

// File: rtl/reload_timer.sv
// Down-counting timeout timer: load restarts at TIMEOUT_CYC-1, tick counts down, expired flags zero.
module reload_timer #(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count;

  // expired is kept as a register that mirrors (count == 0), so it never glitches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      expired <= 1'b1;
    end else if (load) begin
      count   <= RELOAD;
      expired <= (RELOAD == '0);
    end else if (tick && !expired) begin
      count   <= count - CNT_W'(1);
      expired <= (count == CNT_W'(1));
    end
  end

endmodule

// File: rtl/measure_requester.sv
// Host-side measurement initiator: sends one command byte, collects a 3-byte LSB-first reply
// with a per-byte timeout, and publishes the assembled 24-bit result.
module measure_requester
  import meas_link_pkg::*;
#(
  parameter logic [7:0]  CMD_BYTE    = CMD_MEASURE,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned RES_W       = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  input  logic             rx_ready,
  input  logic [7:0]       rx_data,
  output logic [RES_W-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic             timeout_err
);

  meas_state_e      state, state_d;
  logic [RES_W-1:0] shadow, shadow_d, result_d;
  logic             tx_start_d, result_valid_d, timeout_err_d;
  logic             tmr_load, tmr_tick, tmr_expired;

  assign tx_data = CMD_BYTE;

  reload_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load),
    .tick   (tmr_tick),
    .expired(tmr_expired)
  );

  // Next-state, byte assembly and output decode
  always_comb begin
    state_d        = state;
    shadow_d       = shadow;
    result_d       = result;
    tx_start_d     = 1'b0;
    result_valid_d = 1'b0;
    timeout_err_d  = timeout_err;
    tmr_load       = 1'b0;
    tmr_tick       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d       = SEND;
          timeout_err_d = 1'b0;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tmr_load   = 1'b1;
          state_d    = RX0;
        end
      end
      RX0, RX1, RX2: begin
        // A byte arriving in the expiry cycle takes priority over the timeout
        if (rx_ready) begin
          tmr_load = 1'b1;
          if (state == RX0) begin
            shadow_d[0 +: BYTE_W] = rx_data;
            state_d               = RX1;
          end else if (state == RX1) begin
            shadow_d[BYTE_W +: BYTE_W] = rx_data;
            state_d                    = RX2;
          end else begin
            shadow_d[2*BYTE_W +: BYTE_W] = rx_data;
            result_d                     = shadow_d;
            result_valid_d               = 1'b1;
            state_d                      = DONE;
          end
        end else if (tmr_expired) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          tmr_tick = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      shadow       <= '0;
      result       <= '0;
      tx_start     <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_d;
      shadow       <= shadow_d;
      result       <= result_d;
      tx_start     <= tx_start_d;
      result_valid <= result_valid_d;
      busy         <= (state_d != IDLE);
      timeout_err  <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_measure_requester.sv
// Self-checking bench for measure_requester: vector table, directed corner cases, random vs model.
module tb_measure_requester;

  localparam int unsigned T = 100;

  logic        clk = 1'b0;
  logic        reset, start, tx_busy, rx_ready;
  logic [7:0]  rx_data, tx_data;
  logic        tx_start, result_valid, busy, timeout_err;
  logic [23:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  measure_requester #(
    .CMD_BYTE   (8'h01),
    .TIMEOUT_CYC(T),
    .RES_W      (24)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .tx_busy     (tx_busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .result      (result),
    .result_valid(result_valid),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic        st, txb, rxr;
    logic [7:0]  rxd;
    logic        e_tx, e_valid, e_busy, e_err;
    logic [23:0] e_res;
  } vec_t;

  vec_t vecs[17];

  // Transaction-level reference: phase, bytes collected and the cycle of the last timer restart
  int          k, m_phase, m_got, m_last;
  logic [23:0] m_acc, m_res;
  logic        m_tx, m_valid, m_err;
  bit          model_on = 1'b0;

  function void model_reset();
    k = 0; m_phase = 0; m_got = 0; m_last = 0;
    m_acc = '0; m_res = '0; m_tx = 1'b0; m_valid = 1'b0; m_err = 1'b0;
  endfunction

  function void model_update();
    k++;
    m_tx    = 1'b0;
    m_valid = 1'b0;
    case (m_phase)
      0: if (start) begin m_phase = 1; m_err = 1'b0; end
      1: if (!tx_busy) begin m_tx = 1'b1; m_phase = 2; m_got = 0; m_acc = '0; m_last = k; end
      2: begin
        if (rx_ready) begin
          m_acc[8*m_got +: 8] = rx_data;
          m_got++;
          m_last = k;
          if (m_got == 3) begin m_res = m_acc; m_valid = 1'b1; m_phase = 3; end
        end else if (k - m_last == int'(T)) begin
          m_phase = 0;
          m_err   = 1'b1;
        end
      end
      default: m_phase = 0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    if (model_on) model_update();
    #1;
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic chk24(input string name, input logic [23:0] got, input logic [23:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; tx_busy = 1'b0; rx_ready = 1'b0; rx_data = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_ready = 1'b1; rx_data = b;
    step();
    rx_ready = 1'b0;
  endtask

  logic any_tx, any_err;

  initial begin
    // st txb rxr rxd  | tx valid busy err result
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h56, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h34, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 1'b0, 24'h123456};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 24'h123456};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 24'h123456};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 24'h123456};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 24'h123456};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 24'h123456};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 24'h123456};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 24'h123456};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 24'h030201};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 24'h030201};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 24'h030201};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 24'h030201};

    reset = 1'b1;
    idle_inputs();
    step(); step();
    chk1("rst_tx_start", tx_start, 1'b0);
    chk1("rst_valid", result_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_err", timeout_err, 1'b0);
    chk24("rst_result", result, 24'h0);
    chk24("tx_data", 24'(tx_data), 24'h000001);
    reset = 1'b0;
    step();

    // Basic transaction, ignored starts, stray bytes in IDLE
    foreach (vecs[i]) begin
      start = vecs[i].st; tx_busy = vecs[i].txb; rx_ready = vecs[i].rxr; rx_data = vecs[i].rxd;
      step();
      chk1($sformatf("vec%0d_tx_start", i), tx_start, vecs[i].e_tx);
      chk1($sformatf("vec%0d_valid", i), result_valid, vecs[i].e_valid);
      chk1($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      chk1($sformatf("vec%0d_err", i), timeout_err, vecs[i].e_err);
      chk24($sformatf("vec%0d_result", i), result, vecs[i].e_res);
    end
    idle_inputs();

    // Transmitter held busy for 200 cycles: no tx_start, no timeout
    start = 1'b1; step(); start = 1'b0;
    tx_busy = 1'b1; any_tx = 1'b0; any_err = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      any_tx  |= tx_start;
      any_err |= timeout_err;
    end
    chk1("busyhold_no_tx", any_tx, 1'b0);
    chk1("busyhold_no_err", any_err, 1'b0);
    chk1("busyhold_busy", busy, 1'b1);
    tx_busy = 1'b0; step();
    chk1("busyhold_tx_start", tx_start, 1'b1);

    // Only two reply bytes: timeout exactly T cycles after the second
    send_byte(8'hAB);
    send_byte(8'hCD);
    repeat (T - 1) step();
    chk1("to_err_early", timeout_err, 1'b0);
    chk1("to_busy_early", busy, 1'b1);
    step();
    chk1("to_err", timeout_err, 1'b1);
    chk1("to_busy", busy, 1'b0);
    chk24("to_result_kept", result, 24'h030201);
    step();
    chk1("to_err_sticky", timeout_err, 1'b1);
    start = 1'b1; step(); start = 1'b0;
    chk1("to_err_cleared", timeout_err, 1'b0);

    // Third byte lands in the expiry cycle: byte wins
    step();
    chk1("race_tx_start", tx_start, 1'b1);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (T - 1) step();
    send_byte(8'h33);
    chk1("race_valid", result_valid, 1'b1);
    chk1("race_err", timeout_err, 1'b0);
    chk24("race_result", result, 24'h332211);
    step();
    chk1("race_err_after", timeout_err, 1'b0);
    chk1("race_valid_once", result_valid, 1'b0);

    // Reset during RX1, then a clean transaction
    start = 1'b1; step(); start = 1'b0;
    step();
    send_byte(8'h99);
    reset = 1'b1;
    #1;
    chk1("midrst_busy", busy, 1'b0);
    chk24("midrst_result", result, 24'h0);
    step();
    reset = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    step();
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    chk1("midrst_valid", result_valid, 1'b1);
    chk24("midrst_result_new", result, 24'hCCBBAA);
    step();

    // Random stimulus against the reference model
    reset = 1'b1; idle_inputs();
    step();
    reset = 1'b0;
    model_reset();
    model_on = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      start    = ($urandom_range(0, 7) == 0);
      tx_busy  = ($urandom_range(0, 1) == 1);
      rx_ready = ($urandom_range(0, 29) == 0);
      rx_data  = 8'($urandom);
      step();
      chk1($sformatf("rnd%0d_tx_start", i), tx_start, m_tx);
      chk1($sformatf("rnd%0d_valid", i), result_valid, m_valid);
      chk1($sformatf("rnd%0d_busy", i), busy, m_phase != 0);
      chk1($sformatf("rnd%0d_err", i), timeout_err, m_err);
      chk24($sformatf("rnd%0d_result", i), result, m_res);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
